full_chain: RTL

Parametrised forward-kinematics chain sequencer for the IK solver. It owns one start/done transaction. Per joint it issues the DH parameters to the shared `t_block` pipeline, collects the per-joint transforms T_k, and drives the shared 4x4 `mat_mult` unit to accumulate the cumulative transforms T_0k = T_0 · T_1 ··· T_k. It replaces the fixed six-joint, count-scheduled chain stage: the schedule is generated internally from the latency parameters, and completion is signalled by handshake.

---
 rtl/full_chain.sv | 236 +++++++++++++++++++++++
 1 files changed

// File: rtl/full_chain.sv
// full_chain: forward-kinematics chain sequencer feeding the shared t_block and mat_mult units.
// Optional macro FULL_CHAIN_ACTIVE_JOINTS_EN adds an active_joints input sampled at start.
module full_chain #(
    parameter int NUM_JOINTS = 6,
    parameter int WIDTH      = 36,
    parameter int TB_LATENCY = 28,
    parameter int MM_LATENCY = 12
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        en,
    input  logic                                        start,
`ifdef FULL_CHAIN_ACTIVE_JOINTS_EN
    input  logic [3:0]                                  active_joints,
`endif
    input  logic [NUM_JOINTS-1:0][3:0][WIDTH-1:0]       dh_param,
    output logic                                        busy,
    output logic                                        done,
    output logic [WIDTH-1:0]                            tb_theta,
    output logic [WIDTH-1:0]                            tb_a,
    output logic [WIDTH-1:0]                            tb_d,
    output logic [WIDTH-1:0]                            tb_alpha,
    input  logic [3:0][3:0][WIDTH-1:0]                  tb_t_matrix,
    output logic [3:0][3:0][WIDTH-1:0]                  mm_a,
    output logic [3:0][3:0][WIDTH-1:0]                  mm_b,
    input  logic [3:0][3:0][WIDTH-1:0]                  mm_result,
    output logic [NUM_JOINTS-1:0][3:0][3:0][WIDTH-1:0]  full_matrix,
    output logic [NUM_JOINTS-1:0]                       matrix_valid
);
    localparam int CW = $clog2(NUM_JOINTS + 1);
    localparam int MW = $clog2(MM_LATENCY + 1);

    typedef logic [3:0][3:0][WIDTH-1:0] mat_t;
    typedef enum logic [2:0] {IDLE, ISSUE, COLLECT, MULT, FIN} state_t;

    state_t                                     state_q, state_d;
    logic [CW-1:0]                              iss_idx_q, iss_idx_d;
    logic [CW-1:0]                              n_act_q, n_act_d;
    logic [CW-1:0]                              cap_cnt_q, cap_cnt_d;
    logic [CW-1:0]                              k_q, k_d;
    logic [MW-1:0]                              mm_wait_q, mm_wait_d;
    logic [TB_LATENCY-1:0]                      pipe_q, pipe_d;
    logic [NUM_JOINTS-1:0][3:0][3:0][WIDTH-1:0] t_q, t_d, full_q, full_d;
    logic [NUM_JOINTS-1:0]                      valid_q, valid_d;
    logic [WIDTH-1:0]                           th_q, th_d, a_q, a_d, d_q, d_d, al_q, al_d;
    mat_t                                       mma_q, mma_d, mmb_q, mmb_d;
    logic                                       busy_q, busy_d, done_q, done_d;

    logic [CW-1:0] n_start;
    logic          cap_fire;
    mat_t          t_cur, full_prev;

    // Issue tokens travel down pipe_q so each T_k lands exactly TB_LATENCY enabled cycles later.
    assign cap_fire = pipe_q[TB_LATENCY-1];

    always_comb begin
`ifdef FULL_CHAIN_ACTIVE_JOINTS_EN
        if (active_joints == 4'd0 || int'(active_joints) > NUM_JOINTS) n_start = CW'(NUM_JOINTS);
        else                                                             n_start = CW'(active_joints);
`else
        n_start = CW'(NUM_JOINTS);
`endif
    end

    always_comb begin
        t_cur     = '0;
        full_prev = '0;
        for (int i = 0; i < NUM_JOINTS; i++) begin
            if (k_q == CW'(i))     t_cur     = t_q[i];
            if (k_q == CW'(i + 1)) full_prev = full_q[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        iss_idx_d = iss_idx_q;
        n_act_d   = n_act_q;
        cap_cnt_d = cap_cnt_q;
        k_d       = k_q;
        mm_wait_d = mm_wait_q;
        pipe_d    = pipe_q << 1;
        t_d       = t_q;
        full_d    = full_q;
        valid_d   = valid_q;
        th_d      = th_q;
        a_d       = a_q;
        d_d       = d_q;
        al_d      = al_q;
        mma_d     = mma_q;
        mmb_d     = mmb_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        if (cap_fire) begin
            for (int i = 0; i < NUM_JOINTS; i++)
                if (cap_cnt_q == CW'(i)) t_d[i] = tb_t_matrix;
            if (cap_cnt_q == '0) begin
                full_d[0]  = tb_t_matrix;
                valid_d[0] = 1'b1;
            end
            cap_cnt_d = cap_cnt_q + CW'(1);
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d   = ISSUE;
                    valid_d   = '0;
                    iss_idx_d = '0;
                    cap_cnt_d = '0;
                    k_d       = CW'(1);
                    mm_wait_d = '0;
                    n_act_d   = n_start;
                    busy_d    = 1'b1;
                end
            end
            ISSUE: begin
                if (iss_idx_q < n_act_q) begin
                    for (int j = 0; j < NUM_JOINTS; j++) begin
                        if (iss_idx_q == CW'(j)) begin
                            th_d = dh_param[j][0];
                            a_d  = dh_param[j][1];
                            d_d  = dh_param[j][2];
                            al_d = dh_param[j][3];
                        end
                    end
                    pipe_d[0] = 1'b1;
                    iss_idx_d = iss_idx_q + CW'(1);
                end else begin
                    th_d    = '0;
                    a_d     = '0;
                    d_d     = '0;
                    al_d    = '0;
                    state_d = COLLECT;
                end
            end
            COLLECT: begin
                if (n_act_q == CW'(1)) begin
                    if (cap_cnt_q != '0 || cap_fire) state_d = FIN;
                end else if (cap_cnt_q >= CW'(2) || (cap_fire && cap_cnt_q == CW'(1))) begin
                    state_d = MULT;
                end
            end
            MULT: begin
                if (mm_wait_q == '0) begin
                    // T[k] may be arriving this very cycle; forward it rather than lose a cycle.
                    if (cap_cnt_q > k_q) begin
                        mma_d     = full_prev;
                        mmb_d     = t_cur;
                        mm_wait_d = MW'(MM_LATENCY);
                    end else if (cap_fire && cap_cnt_q == k_q) begin
                        mma_d     = full_prev;
                        mmb_d     = tb_t_matrix;
                        mm_wait_d = MW'(MM_LATENCY);
                    end
                end else begin
                    mm_wait_d = mm_wait_q - MW'(1);
                    if (mm_wait_q == MW'(1)) begin
                        for (int i = 0; i < NUM_JOINTS; i++) begin
                            if (k_q == CW'(i)) begin
                                full_d[i]  = mm_result;
                                valid_d[i] = 1'b1;
                            end
                        end
                        k_d = k_q + CW'(1);
                        if (k_q == n_act_q - CW'(1)) state_d = FIN;
                    end
                end
            end
            FIN: begin
                mma_d   = '0;
                mmb_d   = '0;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)     state_q <= IDLE;
        else if (en) state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            iss_idx_q <= '0;
            n_act_q   <= '0;
            cap_cnt_q <= '0;
            k_q       <= '0;
            mm_wait_q <= '0;
            pipe_q    <= '0;
            t_q       <= '0;
            full_q    <= '0;
            valid_q   <= '0;
            th_q      <= '0;
            a_q       <= '0;
            d_q       <= '0;
            al_q      <= '0;
            mma_q     <= '0;
            mmb_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else if (en) begin
            iss_idx_q <= iss_idx_d;
            n_act_q   <= n_act_d;
            cap_cnt_q <= cap_cnt_d;
            k_q       <= k_d;
            mm_wait_q <= mm_wait_d;
            pipe_q    <= pipe_d;
            t_q       <= t_d;
            full_q    <= full_d;
            valid_q   <= valid_d;
            th_q      <= th_d;
            a_q       <= a_d;
            d_q       <= d_d;
            al_q      <= al_d;
            mma_q     <= mma_d;
            mmb_q     <= mmb_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign tb_theta     = th_q;
    assign tb_a         = a_q;
    assign tb_d         = d_q;
    assign tb_alpha     = al_q;
    assign mm_a         = mma_q;
    assign mm_b         = mmb_q;
    assign full_matrix  = full_q;
    assign matrix_valid = valid_q;
endmodule
